// File: rtl/day10_pkg.sv
// Shared definitions for the streaming day-10 machine configurator.
//   cms_state_e     : controller state encoding
//   cms_result_t    : result beat layout {overflow, found, presses} for the
//                     default six-button configuration
//   presses_width() : width needed to count 0..max_buttons presses (min 1)
package day10_pkg;

    typedef enum logic [1:0] {
        CMS_LOAD_TARGET  = 2'd0,
        CMS_LOAD_BUTTONS = 2'd1,
        CMS_SEARCH       = 2'd2,
        CMS_EMIT         = 2'd3
    } cms_state_e;

    function automatic int presses_width(input int max_buttons);
        int w;
        w = $clog2(max_buttons + 1);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int CMS_PRESSES_W = presses_width(6);

    typedef struct packed {
        logic                     overflow;
        logic                     found;
        logic [CMS_PRESSES_W-1:0] presses;
    } cms_result_t;

endpackage

// File: rtl/configure_machine_stream_if.sv
// AXI-Stream style link used for both the machine-description input and the
// result output of the configurator.
//   tdata  : payload, DATA_W bits
//   tvalid : producer has a beat
//   tready : consumer accepts the beat
//   tlast  : final beat of a packet
// master = producer side, slave = consumer side.
interface configure_machine_stream_if #(
    parameter int DATA_W = 6
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ctz_encoder.sv
// Trailing-zero counter: idx_o is the position of the lowest set bit of
// value_i (0 when value_i is zero). Drives the Gray-code bit to flip.
//   value_i : WIDTH-bit input
//   idx_o   : index of the least significant set bit
module ctz_encoder #(
    parameter int WIDTH = 6,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idx_o = value_i[i] ? IDX_W'(i) : idx_o;
        end
    end

endmodule

// File: rtl/configure_machine_stream.sv
// Streaming machine configurator. Each machine arrives as a target light
// pattern followed by button toggle masks (tlast on the final beat). The
// minimum number of presses reaching the target is found by Gray-code
// subset enumeration, one subset per cycle, and emitted as one result beat.
//   clk, rst_n    : clock, synchronous active-low reset
//   s_axis        : machine description input (slave)
//   m_axis        : result output {overflow, found, presses} (master)
//   clear_total   : synchronous clear of the running totals
//   total_presses : sum of presses over found results (wraps)
//   num_machines  : number of results emitted (wraps)
module configure_machine_stream
    import day10_pkg::*;
#(
    parameter int MAX_NUM_LIGHTS  = 6,
    parameter int MAX_NUM_BUTTONS = 6,
    parameter int TOTAL_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    configure_machine_stream_if.slave  s_axis,
    configure_machine_stream_if.master m_axis,
    input  logic                 clear_total,
    output logic [TOTAL_W-1:0]   total_presses,
    output logic [TOTAL_W-1:0]   num_machines
);

    localparam int PRESSES_W = presses_width(MAX_NUM_BUTTONS);
    localparam int RESULT_W  = PRESSES_W + 2;
    localparam int IDX_W     = (MAX_NUM_BUTTONS > 1) ? $clog2(MAX_NUM_BUTTONS) : 1;

    localparam logic [1:0] ST_LOAD_TARGET  = CMS_LOAD_TARGET;
    localparam logic [1:0] ST_LOAD_BUTTONS = CMS_LOAD_BUTTONS;
    localparam logic [1:0] ST_SEARCH       = CMS_SEARCH;
    localparam logic [1:0] ST_EMIT         = CMS_EMIT;

    localparam logic [PRESSES_W-1:0]       NB_MAX = PRESSES_W'(MAX_NUM_BUTTONS);
    localparam logic [MAX_NUM_BUTTONS-1:0] K_ONES = {MAX_NUM_BUTTONS{1'b1}};

    logic [1:0]                state_q, state_d;
    logic [MAX_NUM_LIGHTS-1:0] target_q, target_d;
    logic [MAX_NUM_LIGHTS-1:0] mask_q [MAX_NUM_BUTTONS];
    logic [MAX_NUM_LIGHTS-1:0] mask_d [MAX_NUM_BUTTONS];
    logic [PRESSES_W-1:0]      n_q, n_d;
    logic                      ovf_q, ovf_d;
    logic                      found_q, found_d;
    logic [PRESSES_W-1:0]      best_q, best_d;
    logic [MAX_NUM_BUTTONS-1:0] k_q, k_d;
    logic [MAX_NUM_BUTTONS-1:0] gray_q, gray_d;
    logic [MAX_NUM_LIGHTS-1:0] acc_q, acc_d;
    logic [PRESSES_W-1:0]      pop_q, pop_d;
    logic                      m_tvalid_q, m_tvalid_d;
    logic [RESULT_W-1:0]       m_tdata_q, m_tdata_d;
    logic [TOTAL_W-1:0]        total_q, total_d;
    logic [TOTAL_W-1:0]        count_q, count_d;

    logic                       s_ready_s, s_hs_s, m_hs_s;
    logic [IDX_W-1:0]           idx_s;
    logic [MAX_NUM_BUTTONS-1:0] gray_flip_s, gray_new_s, k_last_s;
    logic [MAX_NUM_LIGHTS-1:0]  acc_new_s;
    logic [PRESSES_W-1:0]       pop_new_s;

    ctz_encoder #(.WIDTH(MAX_NUM_BUTTONS), .IDX_W(IDX_W)) u_ctz (
        .value_i (k_q),
        .idx_o   (idx_s)
    );

    // Input is accepted only while loading and never while reset is held.
    assign s_ready_s      = rst_n && ((state_q == ST_LOAD_TARGET) || (state_q == ST_LOAD_BUTTONS));
    assign s_hs_s         = s_axis.tvalid && s_ready_s;
    assign m_hs_s         = m_tvalid_q && m_axis.tready;
    assign s_axis.tready  = s_ready_s;
    assign m_axis.tvalid  = m_tvalid_q;
    assign m_axis.tdata   = m_tdata_q;
    assign m_axis.tlast   = 1'b1;
    assign total_presses  = total_q;
    assign num_machines   = count_q;
    // Final subset index 2^n - 1 for the loaded button count.
    assign k_last_s       = K_ONES >> (NB_MAX - n_q);

    // One Gray-code step: flip the trailing-zero bit of k, update XOR and popcount.
    always_comb begin
        gray_flip_s        = '0;
        gray_flip_s[idx_s] = 1'b1;
        gray_new_s         = gray_q ^ gray_flip_s;
        acc_new_s          = acc_q ^ mask_q[idx_s];
        pop_new_s          = gray_new_s[idx_s] ? (pop_q + PRESSES_W'(1)) : (pop_q - PRESSES_W'(1));
    end

    // Controller next-state, search bookkeeping, result beat and totals.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        mask_d     = mask_q;
        n_d        = n_q;
        ovf_d      = ovf_q;
        found_d    = found_q;
        best_d     = best_q;
        k_d        = k_q;
        gray_d     = gray_q;
        acc_d      = acc_q;
        pop_d      = pop_q;
        m_tdata_d  = m_tdata_q;
        total_d    = total_q;
        count_d    = count_q;

        case (state_q)
            ST_LOAD_TARGET: begin
                if (s_hs_s) begin
                    target_d = s_axis.tdata;
                    n_d      = '0;
                    ovf_d    = 1'b0;
                    best_d   = '0;
                    // An all-off target is already solved by the empty subset.
                    found_d  = (s_axis.tdata == '0);
                    state_d  = s_axis.tlast ? ST_EMIT : ST_LOAD_BUTTONS;
                end else begin
                    state_d  = ST_LOAD_TARGET;
                end
            end
            ST_LOAD_BUTTONS: begin
                if (s_hs_s) begin
                    if (n_q == NB_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        mask_d[n_q] = s_axis.tdata;
                        n_d         = n_q + PRESSES_W'(1);
                    end
                    if (!s_axis.tlast) begin
                        state_d = ST_LOAD_BUTTONS;
                    end else if (ovf_d) begin
                        found_d = 1'b0;
                        state_d = ST_EMIT;
                    end else begin
                        k_d     = {{(MAX_NUM_BUTTONS-1){1'b0}}, 1'b1};
                        acc_d   = '0;
                        pop_d   = '0;
                        gray_d  = '0;
                        state_d = ST_SEARCH;
                    end
                end else begin
                    state_d = ST_LOAD_BUTTONS;
                end
            end
            ST_SEARCH: begin
                gray_d = gray_new_s;
                acc_d  = acc_new_s;
                pop_d  = pop_new_s;
                if ((acc_new_s == target_q) && (!found_q || (pop_new_s < best_q))) begin
                    best_d  = pop_new_s;
                    found_d = 1'b1;
                end else begin
                    best_d  = best_q;
                end
                if (k_q == k_last_s) begin
                    state_d = ST_EMIT;
                end else begin
                    k_d     = k_q + MAX_NUM_BUTTONS'(1);
                end
            end
            ST_EMIT: begin
                state_d = m_hs_s ? ST_LOAD_TARGET : ST_EMIT;
            end
            default: begin
                state_d = ST_LOAD_TARGET;
            end
        endcase

        // Result beat captured on entry to EMIT and frozen until accepted.
        m_tvalid_d = (state_q == ST_EMIT) && !m_hs_s;
        if ((state_q == ST_EMIT) && !m_tvalid_q) begin
            m_tdata_d = {ovf_q, found_q, (found_q ? best_q : {PRESSES_W{1'b0}})};
        end else begin
            m_tdata_d = m_tdata_q;
        end

        // Clear first, then add, so a coincident result lands in the fresh totals.
        if (clear_total) begin
            total_d = '0;
            count_d = '0;
        end else begin
            total_d = total_q;
            count_d = count_q;
        end
        if (m_hs_s) begin
            count_d = count_d + TOTAL_W'(1);
            total_d = m_tdata_q[PRESSES_W] ? (total_d + TOTAL_W'(m_tdata_q[PRESSES_W-1:0])) : total_d;
        end else begin
            count_d = count_d;
        end
    end

    // State registers with synchronous active-low reset; masks need no reset.
    always_ff @(posedge clk) begin
        mask_q <= mask_d;
        if (!rst_n) begin
            state_q    <= ST_LOAD_TARGET;
            target_q   <= '0;
            n_q        <= '0;
            ovf_q      <= 1'b0;
            found_q    <= 1'b0;
            best_q     <= '0;
            k_q        <= '0;
            gray_q     <= '0;
            acc_q      <= '0;
            pop_q      <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            total_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            n_q        <= n_d;
            ovf_q      <= ovf_d;
            found_q    <= found_d;
            best_q     <= best_d;
            k_q        <= k_d;
            gray_q     <= gray_d;
            acc_q      <= acc_d;
            pop_q      <= pop_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            total_q    <= total_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_configure_machine_stream.sv
// Self-checking bench for configure_machine_stream: directed scenarios plus
// randomized machines checked against a brute-force subset reference model.
module tb_configure_machine_stream;
    import day10_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_total = 1'b0;
    logic [15:0] total_presses;
    logic [15:0] num_machines;

    configure_machine_stream_if #(.DATA_W(6)) s_if ();
    configure_machine_stream_if #(.DATA_W(5)) m_if ();

    configure_machine_stream #(
        .MAX_NUM_LIGHTS (6),
        .MAX_NUM_BUTTONS(6),
        .TOTAL_W        (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .clear_total  (clear_total),
        .total_presses(total_presses),
        .num_machines (num_machines)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [5:0]  btn_g [16];
    int          accepted_g;
    int unsigned tot_m = 0;
    int unsigned cnt_m = 0;

    function automatic cms_result_t mk(input logic o, input logic f, input int p);
        cms_result_t r;
        r.overflow = o;
        r.found    = f;
        r.presses  = 3'(p);
        return r;
    endfunction

    // Brute force over every subset of the buttons: minimum popcount reaching tgt.
    function automatic cms_result_t model(input logic [5:0] tgt, input int nb);
        int best = 99;
        if (nb > 6) return mk(1'b1, 1'b0, 0);
        for (int s = 0; s < (1 << nb); s++) begin
            logic [5:0] x = 6'd0;
            int p = 0;
            for (int i = 0; i < nb; i++) begin
                if ((s >> i) & 1) begin
                    x = x ^ btn_g[i];
                    p++;
                end
            end
            if (x == tgt && p < best) best = p;
        end
        if (best == 99) return mk(1'b0, 1'b0, 0);
        return mk(1'b0, 1'b1, best);
    endfunction

    function automatic int model_lat(input int nb);
        return (nb == 0 || nb > 6) ? 1 : (1 << nb);
    endfunction

    task automatic model_account(input cms_result_t r);
        cnt_m = (cnt_m + 1) & 32'hFFFF;
        if (r.found) tot_m = (tot_m + r.presses) & 32'hFFFF;
    endtask

    task automatic send_beat(input logic [5:0] d, input logic last);
        int t = 0;
        s_if.tdata  = d;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        while (!s_if.tready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (s_if.tready) accepted_g++;
        else begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout: tready stayed 0, required 1");
        end
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_machine(input logic [5:0] tgt, input int nb);
        accepted_g = 0;
        send_beat(tgt, (nb == 0));
        for (int i = 0; i < nb; i++) send_beat(btn_g[i], (i == nb - 1));
    endtask

    // Counts cycles from the tlast handshake edge until tvalid is seen.
    task automatic wait_valid(output cms_result_t r, output int lat);
        lat = 0;
        while (!m_if.tvalid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!m_if.tvalid) begin
            n_checks++; n_errors++;
            $display("FAIL result_timeout: tvalid=0 after %0d cycles, required 1", lat);
        end
        r = m_if.tdata;
    endtask

    task automatic run_machine(input logic [5:0] tgt, input int nb, output cms_result_t r, output int lat);
        send_machine(tgt, nb);
        wait_valid(r, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (s_if.tready !== 1'b0) begin n_errors++; $display("FAIL reset_tready: got %b, required 0", s_if.tready); end
        n_checks++;
        if (m_if.tvalid !== 1'b0 || m_if.tdata !== 5'd0) begin
            n_errors++; $display("FAIL reset_result: tvalid=%b tdata=%h, required 0/00", m_if.tvalid, m_if.tdata);
        end
        n_checks++;
        if (total_presses !== 16'd0 || num_machines !== 16'd0) begin
            n_errors++; $display("FAIL reset_totals: %0d/%0d, required 0/0", total_presses, num_machines);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (s_if.tready !== 1'b1) begin n_errors++; $display("FAIL release_tready: got %b, required 1", s_if.tready); end
        tot_m = 0; cnt_m = 0;
    endtask

    task automatic test_aoc_back_to_back();
        cms_result_t r;
        int lat;
        logic [5:0] tg [3] = '{6'h06, 6'h08, 6'h2E};
        int nbs [3] = '{6, 5, 4};
        int exp_p [3] = '{2, 3, 2};
        logic [5:0] m0 [6] = '{6'h08, 6'h0A, 6'h04, 6'h0C, 6'h05, 6'h03};
        logic [5:0] m1 [5] = '{6'h1D, 6'h0C, 6'h11, 6'h07, 6'h1E};
        logic [5:0] m2 [4] = '{6'h1F, 6'h19, 6'h37, 6'h06};
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < nbs[m]; i++) btn_g[i] = (m == 0) ? m0[i] : (m == 1) ? m1[i] : m2[i];
            run_machine(tg[m], nbs[m], r, lat);
            model_account(r);
            n_checks++;
            if (r !== mk(1'b0, 1'b1, exp_p[m])) begin
                n_errors++; $display("FAIL aoc_result_%0d: got %h, required %h", m, r, mk(1'b0, 1'b1, exp_p[m]));
            end
            n_checks++;
            if (lat != (1 << nbs[m])) begin
                n_errors++; $display("FAIL aoc_latency_%0d: got %0d, required %0d", m, lat, 1 << nbs[m]);
            end
        end
        n_checks++;
        if (total_presses !== 16'd7 || num_machines !== 16'd3) begin
            n_errors++; $display("FAIL aoc_totals: %0d/%0d, required 7/3", total_presses, num_machines);
        end
        n_checks++;
        if (s_if.tready !== 1'b1) begin n_errors++; $display("FAIL next_target_ready: got %b, required 1", s_if.tready); end
    endtask

    task automatic test_zero_target();
        cms_result_t r;
        int lat;
        btn_g[0] = 6'h01; btn_g[1] = 6'h02;
        run_machine(6'h00, 2, r, lat);
        model_account(r);
        n_checks++;
        if (r !== mk(1'b0, 1'b1, 0) || lat != 4) begin
            n_errors++; $display("FAIL zero_target_2btn: got %h lat %0d, required %h lat 4", r, lat, mk(1'b0, 1'b1, 0));
        end
        run_machine(6'h00, 0, r, lat);
        model_account(r);
        n_checks++;
        if (r !== mk(1'b0, 1'b1, 0) || lat != 1) begin
            n_errors++; $display("FAIL zero_target_tlast: got %h lat %0d, required %h lat 1", r, lat, mk(1'b0, 1'b1, 0));
        end
    endtask

    task automatic test_unsolvable();
        cms_result_t r;
        int lat;
        btn_g[0] = 6'h02; btn_g[1] = 6'h04;
        run_machine(6'h01, 2, r, lat);
        model_account(r);
        n_checks++;
        if (r !== mk(1'b0, 1'b0, 0)) begin n_errors++; $display("FAIL unsolvable_result: got %h, required 00", r); end
        n_checks++;
        if (total_presses !== 16'(tot_m) || num_machines !== 16'(cnt_m)) begin
            n_errors++; $display("FAIL unsolvable_totals: %0d/%0d, required %0d/%0d", total_presses, num_machines, tot_m, cnt_m);
        end
    endtask

    task automatic test_overflow();
        cms_result_t r;
        int lat;
        for (int i = 0; i < 8; i++) btn_g[i] = 6'(1 << (i % 6));
        run_machine(6'h01, 8, r, lat);
        model_account(r);
        n_checks++;
        if (accepted_g != 9) begin n_errors++; $display("FAIL overflow_accepted: got %0d beats, required 9", accepted_g); end
        n_checks++;
        if (r !== mk(1'b1, 1'b0, 0) || lat != 1) begin
            n_errors++; $display("FAIL overflow_result: got %h lat %0d, required %h lat 1", r, lat, mk(1'b1, 1'b0, 0));
        end
    endtask

    task automatic test_backpressure();
        cms_result_t r;
        int lat;
        int bad = 0;
        btn_g[0] = 6'h01; btn_g[1] = 6'h02;
        m_if.tready = 1'b0;
        send_machine(6'h03, 2);
        wait_valid(r, lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== 5'(mk(1'b0, 1'b1, 2)) || s_if.tready !== 1'b0 ||
                total_presses !== 16'(tot_m) || num_machines !== 16'(cnt_m)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL backpressure_hold: %0d bad cycles (tdata %h), required 0", bad, m_if.tdata);
        end
        m_if.tready = 1'b1;
        @(posedge clk); #1;
        model_account(mk(1'b0, 1'b1, 2));
        n_checks++;
        if (total_presses !== 16'(tot_m) || num_machines !== 16'(cnt_m) || m_if.tvalid !== 1'b0) begin
            n_errors++; $display("FAIL backpressure_release: %0d/%0d tvalid %b, required %0d/%0d tvalid 0",
                                 total_presses, num_machines, m_if.tvalid, tot_m, cnt_m);
        end
    endtask

    task automatic test_clear_total();
        cms_result_t r;
        int lat;
        btn_g[0] = 6'h01; btn_g[1] = 6'h02;
        send_machine(6'h03, 2);
        wait_valid(r, lat);
        clear_total = 1'b1;
        @(posedge clk); #1;
        clear_total = 1'b0;
        tot_m = 2; cnt_m = 1;
        n_checks++;
        if (total_presses !== 16'd2 || num_machines !== 16'd1) begin
            n_errors++; $display("FAIL clear_with_result: %0d/%0d, required 2/1", total_presses, num_machines);
        end
    endtask

    task automatic test_reset_mid_search();
        cms_result_t r;
        int lat;
        int seen = 0;
        logic [5:0] m0 [6] = '{6'h08, 6'h0A, 6'h04, 6'h0C, 6'h05, 6'h03};
        for (int i = 0; i < 6; i++) btn_g[i] = m0[i];
        send_machine(6'h06, 6);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tot_m = 0; cnt_m = 0;
        for (int c = 0; c < 80; c++) begin
            if (m_if.tvalid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen != 0) begin n_errors++; $display("FAIL reset_abandon: tvalid high %0d cycles, required 0", seen); end
        run_machine(6'h06, 6, r, lat);
        model_account(r);
        n_checks++;
        if (r !== mk(1'b0, 1'b1, 2) || num_machines !== 16'd1) begin
            n_errors++; $display("FAIL after_reset_machine: got %h count %0d, required %h count 1", r, num_machines, mk(1'b0, 1'b1, 2));
        end
    endtask

    task automatic test_random();
        cms_result_t r, e;
        int lat, nb;
        logic [5:0] tgt;
        for (int m = 0; m < 25; m++) begin
            nb  = $urandom_range(0, 8);
            tgt = 6'($urandom);
            for (int i = 0; i < nb; i++) btn_g[i] = 6'($urandom);
            e = model(tgt, nb);
            run_machine(tgt, nb, r, lat);
            model_account(e);
            n_checks++;
            if (r !== e || lat != model_lat(nb)) begin
                n_errors++; $display("FAIL random_%0d: got %h lat %0d, required %h lat %0d", m, r, lat, e, model_lat(nb));
            end
        end
        n_checks++;
        if (total_presses !== 16'(tot_m) || num_machines !== 16'(cnt_m)) begin
            n_errors++; $display("FAIL random_totals: %0d/%0d, required %0d/%0d", total_presses, num_machines, tot_m, cnt_m);
        end
    endtask

    initial begin
        s_if.tdata  = 6'd0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        test_reset();
        test_aoc_back_to_back();
        test_zero_target();
        test_unsolvable();
        test_overflow();
        test_backpressure();
        test_clear_total();
        test_reset_mid_search();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/configure_machine_stream.md
# configure_machine_stream

Streaming, parametrised successor to the single-machine day-10 configurator. It accepts a sequence of machine descriptions over AXI-Stream: a target light pattern followed by button toggle masks. For each machine it finds the minimum number of button presses whose XOR equals the target, by Gray-code subset enumeration at one subset per cycle. It emits one result beat per machine and keeps a running total of presses across machines for the top-level day-10 answer.

## Interface
- `MAX_NUM_LIGHTS`, 6, width of light pattern and button masks.
- `MAX_NUM_BUTTONS`, 6, maximum buttons per machine; search depth 2^MAX_NUM_BUTTONS.
- `TOTAL_W`, 16, width of running total.
- Derived: `PRESSES_W = $clog2(MAX_NUM_BUTTONS+1)` (min 1); `RESULT_W = PRESSES_W+2`.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `s_axis_tdata`  in  MAX_NUM_LIGHTS  target (first beat) or button mask (later beats); bit i = light i.
- `s_axis_tvalid` / `s_axis_tready` / `s_axis_tlast`  in/out/in  1  tlast marks the final beat of a machine.
- `m_axis_tdata`  out  RESULT_W  {overflow, found, presses}.
- `m_axis_tvalid` / `m_axis_tready`  out/in  1.
- `clear_total`  in  1  synchronous clear of `total_presses` and `num_machines`.
- `total_presses`  out  TOTAL_W  sum of presses over found results, wraps mod 2^TOTAL_W.
- `num_machines`  out  TOTAL_W  count of emitted results, wraps.

## Operation
- States: LOAD_TARGET, LOAD_BUTTONS, SEARCH, EMIT.
- LOAD_TARGET: tready=1. On handshake, latch target, n=0, best=∞, found = (target==0).
  - tlast on this beat → EMIT (n=0).
  - Otherwise → LOAD_BUTTONS.
- LOAD_BUTTONS: tready=1. Each handshake stores a mask at index n and increments n.
  - Beats beyond MAX_NUM_BUTTONS are accepted and discarded; they set `overflow`.
  - On the tlast handshake: overflow → EMIT with found=0, presses=0; else → SEARCH with k=1, acc=0, pop=0, gray=0.
- SEARCH: each cycle, i = ctz(k); gray[i] flips.
  - acc ^= mask[i]; pop ±1 according to the new gray[i].
  - If the new acc == target and the new pop < best: best=pop, found=1.
  - After processing k = 2^n−1 → EMIT. No early exit; latency is deterministic.
- EMIT: m_axis_tvalid=1; tdata = {overflow, found, found ? best : 0}, held stable until m_axis_tready.
  - On handshake: num_machines+=1; total_presses+=presses if found; → LOAD_TARGET.
- clear_total: zeroes both totals. If it coincides with a result handshake, the totals become that result (clear, then add).
- s_axis_tready = 0 in SEARCH and EMIT.

## Timing
- Reset (rst_n low at a clk edge): state=LOAD_TARGET; m_axis_tvalid=0; m_axis_tdata=0; totals=0; n=0; overflow=0.
  - s_axis_tready is 0 while rst_n is low, and 1 the first cycle after.
  - Reset mid-load or mid-search abandons the machine with no result.
- Back-to-back input: target at cycle t, buttons at t+1..t+n.
- From the tlast handshake edge, m_axis_tvalid rises 2^n cycles later. Cases:
  - n=0: 1 cycle.
  - Overflow: 1 cycle.
- m_axis_tvalid, once high, stays high with tdata stable until tready. A new machine's target is accepted the cycle after the result handshake.
- Totals update on the edge of the result handshake and are visible the next cycle.

## Structure
- Package `day10_pkg`: state enum `cms_state_e`, result struct `cms_result_t` {overflow, found, presses}, width helper function for `PRESSES_W`.
- Sub-module `ctz_encoder` (parametrised WIDTH): combinational trailing-zero index of k for the Gray step.
- Button masks: register array `MAX_NUM_BUTTONS × MAX_NUM_LIGHTS`. k: `MAX_NUM_BUTTONS` bits. pop/best: `PRESSES_W` bits.

## Test plan
MAX_NUM_LIGHTS=6 and MAX_NUM_BUTTONS=6 unless stated.
- AoC example, back-to-back:
  - Machine 1: target 0x06, buttons 0x08,0x0A,0x04,0x0C,0x05,0x03 → {0,1,2}.
  - Machine 2: target 0x08, buttons 0x1D,0x0C,0x11,0x07,0x1E → {0,1,3}.
  - Machine 3: target 0x2E, buttons 0x1F,0x19,0x37,0x06 → {0,1,2}.
  - Totals: total_presses=7, num_machines=3; latencies 64/32/16 cycles after tlast.
- Target 0x00 with buttons 0x01,0x02 → {0,1,0} after 4 cycles; target 0x00 with tlast on the target beat → {0,1,0} after 1 cycle.
- Unsolvable: target 0x01, buttons 0x02,0x04 → {0,0,0}; total unchanged; num_machines+1.
- Overflow: target 0x01 plus 8 button beats → all 9 accepted; result {1,0,0} one cycle after tlast.
- Backpressure: m_axis_tready low 10 cycles during EMIT → tdata stable, s_axis_tready=0, totals unchanged until the handshake.
- clear_total coincident with a result of 2 presses → total=2, num_machines=1; rst_n low mid-SEARCH → no result, tvalid=0, next machine solved correctly.
